// File: rtl/cronometro_display_pkg.sv
`default_nettype none
// =============================================================================
// Module      : cronometro_display_pkg
// Description : Shared types, glyph table and limits for the stopwatch display.
// Revision    : 1.0 - initial release
// =============================================================================
package cronometro_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } conv_state_t;

  // Active-low glyphs, bit 0 = segment a ... bit 6 = segment g
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [6:0] CSEG_MAX = 7'd99;
  localparam logic [6:0] SEG_MAX  = 7'd59;

  // Digit-register code that renders as a dash
  localparam logic [3:0] BCD_DASH = 4'hF;

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_DASH;
    endcase
    return g;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cronometro_display_bin2bcd_seq.sv
`default_nettype none
// =============================================================================
// Module      : bin2bcd_seq
// Description : Fixed-latency 7-bit binary to two-digit BCD (double dabble).
// Revision    : 1.0 - initial release
// =============================================================================
module bin2bcd_seq
  import cronometro_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [6:0] i_bin,
  output logic [3:0] o_tens,
  output logic [3:0] o_units,
  output logic [6:0] o_bin_q,
  output logic       o_done
);

  conv_state_t r_state;
  logic [14:0] r_sr;
  logic [2:0]  r_cnt;
  logic [6:0]  r_bin_q;
  logic        r_done;

  logic [3:0]  w_tens_adj;
  logic [3:0]  w_units_adj;
  logic [14:0] w_sr_next;

  always_comb begin
    w_tens_adj  = (r_sr[14:11] >= 4'd5) ? r_sr[14:11] + 4'd3 : r_sr[14:11];
    w_units_adj = (r_sr[10:7]  >= 4'd5) ? r_sr[10:7]  + 4'd3 : r_sr[10:7];
    // Hundreds carry is dropped; such inputs are out of range and shown as dashes
    w_sr_next   = {w_tens_adj[2:0], w_units_adj, r_sr[6:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bin_q <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_sr    <= {8'd0, i_bin};
            r_bin_q <= i_bin;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr <= w_sr_next;
          if (r_cnt == 3'd6) begin
            r_done  <= 1'b1;
            r_state <= UPDATE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        UPDATE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_tens  = r_sr[14:11];
  assign o_units = r_sr[10:7];
  assign o_bin_q = r_bin_q;
  assign o_done  = r_done;

endmodule
`default_nettype wire

// File: rtl/cronometro_display.sv
`default_nettype none
// =============================================================================
// Module      : cronometro_display
// Description : SS.CC stopwatch readout on a 4-digit multiplexed 7-seg display.
// Revision    : 1.0 - initial release
// =============================================================================
module cronometro_display
  import cronometro_display_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cent_seg,
  input  logic [5:0] seg,
  output logic [6:0] seg_out,
  output logic       dp,
  output logic [3:0] an,
  output logic       range_err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  logic [3:0] w_cent_tens;
  logic [3:0] w_cent_units;
  logic [3:0] w_sec_tens;
  logic [3:0] w_sec_units;
  logic [6:0] w_cent_q;
  logic [6:0] w_sec_q;
  logic       w_done_cent;
  logic       w_done_sec;
  logic       w_done;
  logic       w_cent_bad;
  logic       w_sec_bad;

  logic [PW-1:0]   r_presc;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_dig;
  logic            r_range_err;
  logic [3:0]      r_an;
  logic [6:0]      r_seg_out;
  logic            r_dp;

  // Both converters share a permanently asserted start so they stay in lockstep
  bin2bcd_seq u_bcd_cent (
    .clk     (clk),
    .rst     (rst),
    .i_start (1'b1),
    .i_bin   (cent_seg),
    .o_tens  (w_cent_tens),
    .o_units (w_cent_units),
    .o_bin_q (w_cent_q),
    .o_done  (w_done_cent)
  );

  bin2bcd_seq u_bcd_sec (
    .clk     (clk),
    .rst     (rst),
    .i_start (1'b1),
    .i_bin   ({1'b0, seg}),
    .o_tens  (w_sec_tens),
    .o_units (w_sec_units),
    .o_bin_q (w_sec_q),
    .o_done  (w_done_sec)
  );

  assign w_done     = w_done_cent & w_done_sec;
  assign w_cent_bad = (w_cent_q > CSEG_MAX);
  assign w_sec_bad  = (w_sec_q > SEG_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= '0;
      r_dig       <= '0;
      r_range_err <= 1'b0;
      r_an        <= 4'b1110;
      r_seg_out   <= SEG_0;
      r_dp        <= 1'b1;
    end else begin
      if (r_presc == PRESC_LAST) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // All four digits and the error flag change together: no torn readout
      if (w_done) begin
        r_dig[0]    <= w_cent_bad ? BCD_DASH : w_cent_units;
        r_dig[1]    <= w_cent_bad ? BCD_DASH : w_cent_tens;
        r_dig[2]    <= w_sec_bad  ? BCD_DASH : w_sec_units;
        r_dig[3]    <= w_sec_bad  ? BCD_DASH : w_sec_tens;
        r_range_err <= w_cent_bad | w_sec_bad;
      end

      r_an      <= ~(4'b0001 << r_idx);
      r_seg_out <= bcd_to_seg(r_dig[r_idx]);
      r_dp      <= (r_idx != 2'd2);
    end
  end

  assign an        = r_an;
  assign seg_out   = r_seg_out;
  assign dp        = r_dp;
  assign range_err = r_range_err;

endmodule
`default_nettype wire

// File: tb/tb_cronometro_display.sv
`default_nettype none
// =============================================================================
// Module      : tb_cronometro_display
// Description : Scoreboard bench for cronometro_display with SCAN_DIV = 4.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_cronometro_display;
  import cronometro_display_pkg::*;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G9 = 7'b0010000;
  localparam logic [6:0] GD = 7'b0111111;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       rerr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] cent_seg = '0;
  logic [5:0] seg = '0;
  logic [6:0] seg_out;
  logic       dp;
  logic [3:0] an;
  logic       range_err;

  exp_t sb[$];
  logic mon_busy = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cronometro_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cent_seg  (cent_seg),
    .seg       (seg),
    .seg_out   (seg_out),
    .dp        (dp),
    .an        (an),
    .range_err (range_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame, digits listed from an[0] (cent units) to an[3] (sec tens)
  task automatic push_frame(input logic [6:0] g0, input logic [6:0] g1,
                            input logic [6:0] g2, input logic [6:0] g3,
                            input logic rerr);
    sb.push_back('{an: 4'b1110, seg: g0, dp: 1'b1, rerr: rerr});
    sb.push_back('{an: 4'b1101, seg: g1, dp: 1'b1, rerr: rerr});
    sb.push_back('{an: 4'b1011, seg: g2, dp: 1'b0, rerr: rerr});
    sb.push_back('{an: 4'b0111, seg: g3, dp: 1'b1, rerr: rerr});
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || mon_busy) && t < 300) begin
      tick();
      t++;
    end
    check("drain_timeout", (t < 300), 1);
  endtask

  // Monitor: waits for the expected digit slot, then compares the display
  initial begin : monitor
    exp_t e;
    int   waited;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        mon_busy = 1'b1;
        e = sb.pop_front();
        waited = 0;
        while (an !== e.an && waited < 40) begin
          @(negedge clk);
          waited++;
        end
        if (an !== e.an) begin
          check("slot_timeout_an", {28'd0, an}, {28'd0, e.an});
        end else begin
          check("slot_seg", {25'd0, seg_out}, {25'd0, e.seg});
          check("slot_dp", {31'd0, dp}, {31'd0, e.dp});
          check("slot_range_err", {31'd0, range_err}, {31'd0, e.rerr});
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int   found;
    logic [15:0] digs;

    // Reset values from the first edge onwards
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_an", {28'd0, an}, 32'hE);
      check("rst_seg", {25'd0, seg_out}, {25'd0, G0});
      check("rst_dp", {31'd0, dp}, 32'd1);
      check("rst_range_err", {31'd0, range_err}, 32'd0);
    end
    rst = 1'b0;

    // Normal value 42.37
    cent_seg = 7'd37; seg = 6'd42;
    repeat (20) tick();
    push_frame(G7, G3, G2, G4, 1'b0);
    drain();

    // Maximum legal value 59.99
    cent_seg = 7'd99; seg = 6'd59;
    repeat (20) tick();
    push_frame(G9, G9, G9, G5, 1'b0);
    drain();

    // Out-of-range centiseconds
    cent_seg = 7'd100; seg = 6'd12;
    repeat (20) tick();
    push_frame(GD, GD, G2, G1, 1'b1);
    drain();
    cent_seg = 7'd5;
    found = 0;
    for (int k = 1; k <= 18 && found == 0; k++) begin
      tick();
      if (range_err == 1'b0) found = k;
    end
    check("range_err_clear_latency", (found != 0 && found <= 17), 1);
    repeat (20) tick();
    push_frame(G5, G0, G2, G1, 1'b0);
    drain();

    // No tearing: 19 captured, then 20 applied mid-conversion
    cent_seg = 7'd19; seg = 6'd0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 3) cent_seg = 7'd20;
      digs = dut.r_dig;
      if (k < 9)       check("no_tear_pre", {24'd0, digs[7:0]}, 32'h00);
      else if (k < 18) check("no_tear_old", {24'd0, digs[7:0]}, 32'h19);
      else             check("no_tear_new", {24'd0, digs[7:0]}, 32'h20);
    end
    push_frame(G0, G2, G0, G0, 1'b0);
    drain();

    // Reset during SHIFT iteration 3 with 55/33 loaded
    cent_seg = 7'd55; seg = 6'd33;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (13) tick();
    digs = dut.r_dig;
    check("pre_reset_digits", {16'd0, digs}, 32'h3355);
    rst = 1'b1;
    tick();
    digs = dut.r_dig;
    check("midrst_digits", {16'd0, digs}, 32'h0);
    check("midrst_state_idle", (dut.u_bcd_cent.r_state == IDLE), 1);
    check("midrst_an", {28'd0, an}, 32'hE);
    check("midrst_seg", {25'd0, seg_out}, {25'd0, G0});
    check("midrst_range_err", {31'd0, range_err}, 32'd0);
    rst = 1'b0;
    found = 0;
    for (int k = 1; k <= 12 && found == 0; k++) begin
      tick();
      digs = dut.r_dig;
      if (digs == 16'h3355) found = k;
    end
    check("midrst_reload_latency", (found != 0 && found <= 9), 1);
    push_frame(G5, G5, G3, G3, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cronometro_display.md
# cronometro_display

Display-side reader for the stopwatch time outputs. It samples the binary `cent_seg` (0–99) and `seg` (0–59) values and converts each to two BCD digits with a fixed-latency sequential double-dabble. It then drives a 4-digit, time-multiplexed, active-low 7-segment display, showing `SS.CC`. It sits between the stopwatch core and the board display pins.

## Interface
- `SCAN_DIV`, default 50000: `clk` cycles each digit stays enabled. Must be ≥ 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `cent_seg` input, 7 bits: centiseconds, binary. Legal range 0–99.
- `seg` input, 6 bits: seconds, binary. Legal range 0–59.
- `seg_out` output, 7 bits: segment drive, active-low. Bit 0 = a … bit 6 = g.
- `dp` output, 1 bit: decimal point, active-low.
- `an` output, 4 bits: digit enables, active-low, one-hot-zero. Digit mapping:
  - `an[3]` = seconds tens
  - `an[2]` = seconds units
  - `an[1]` = centiseconds tens
  - `an[0]` = centiseconds units
- `range_err` output, 1 bit: high while the displayed sample had an out-of-range field.

## Operation
- **Converter FSM** with states `IDLE`, `SHIFT`, `UPDATE`. It runs continuously.
  - `IDLE`: capture `cent_seg` and `seg` into the shift registers; clear the BCD nibbles; load the iteration counter with 0; go to `SHIFT`.
  - `SHIFT`: performs one double-dabble iteration per cycle, run in parallel for both fields. `seg` is zero-extended to 7 bits.
    - Each iteration: add 3 to every BCD nibble ≥ 5, then shift left by 1.
    - After 7 iterations (counter 0..6), go to `UPDATE`.
  - `UPDATE`: write all four displayed digit registers and `range_err` in the same cycle, so there is no tearing. Go to `IDLE`.
- **Conversion period**: fixed at 9 cycles (1 + 7 + 1). Inputs are sampled only in `IDLE`; changes at any other time are ignored until the next `IDLE`.
- **Range check**, evaluated on the captured values:
  - `cent_seg` > 99: both centisecond digits display a dash.
  - `seg` > 59: both seconds digits display a dash.
  - `range_err` = OR of the two checks, updated in `UPDATE`.
- **Scan**: the prescaler counts 0..`SCAN_DIV`−1.
  - At terminal count, the digit index advances 0→1→2→3→0.
  - `an`, `seg_out` and `dp` are registered from the index and the digit registers.
- **Glyphs**, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - dash = 0111111
  - Leading zeros are shown.
- `dp` = 0 only when index = 2; otherwise 1.

## Timing
- **Reset values**, present in the first cycle after `rst` is sampled high:
  - `an` = 1110
  - `seg_out` = 1000000
  - `dp` = 1
  - `range_err` = 0
  - all digit registers 0, prescaler 0, index 0, FSM `IDLE`
- **Reset mid-conversion**: abandons the conversion. Digit registers go to 0; the previous value is not displayed.
- **Input-to-register latency**: 9 cycles if the change is sampled in `IDLE`, at most 17 cycles worst case. The display outputs reflect a new digit register one cycle after `UPDATE`, during that digit's scan slot.
- **Scan timing**: the index change occurs on the cycle after the prescaler terminal count. Outputs change one cycle later (registered). Each digit is lit for exactly `SCAN_DIV` cycles. Full frame = 4·`SCAN_DIV` cycles.
- **Simultaneous events**: `UPDATE` coinciding with a scan advance. The new index shows the new digit value in the same registered cycle.
- **Wrap-around**: index 3→0 and prescaler max→0 need no special handling.

## Structure
- Package `cronometro_display_pkg` holds:
  - the FSM state enum (`IDLE`, `SHIFT`, `UPDATE`)
  - the glyph constants `SEG_0`..`SEG_9` and `SEG_DASH`
  - the function `bcd_to_seg(logic [3:0]) → logic [6:0]`; values > 9 map to `SEG_DASH`
  - the constants `CSEG_MAX` = 99 and `SEG_MAX` = 59
- Sub-module `bin2bcd_seq`: the double-dabble FSM with a 7-bit input, two BCD nibble outputs and a done pulse. Instantiate it twice (centiseconds, seconds) with a shared start.
- The top level holds the prescaler, scan index, digit registers, range check and output registers.

## Test plan
All scenarios run with `SCAN_DIV` = 4.
- **Reset**: `rst` high for 3 cycles → `an` = 1110, `seg_out` = 1000000, `dp` = 1, `range_err` = 0 from the first post-edge cycle.
- **Normal value**: `cent_seg` = 37, `seg` = 42 held for 20 cycles, then observe one frame. Required per slot:
  - `an` = 1110: `seg_out` = 1111000 (7)
  - `an` = 1101: `seg_out` = 0110000 (3)
  - `an` = 1011: `seg_out` = 0100100 (2), `dp` = 0
  - `an` = 0111: `seg_out` = 0011001 (4)
- **Maximum legal value**: `cent_seg` = 99, `seg` = 59 → digits 9, 9, 9, 5. `range_err` = 0.
- **Out of range**: `cent_seg` = 100, `seg` = 12 → digits 0 and 1 show 0111111; digits 2 and 3 show 2 and 1; `range_err` = 1. Then `cent_seg` = 5 → `range_err` = 0 within 17 cycles.
- **No tearing**: change `cent_seg` from 19 to 20 during `SHIFT`. The digit registers never hold a mix of old and new values (never "10" or "29"). The new value appears after the next full conversion.
- **Reset mid-conversion**: assert `rst` during `SHIFT` iteration 3 with 55/33 loaded → next cycle all digits 0 and FSM in `IDLE`. After release, 55/33 is displayed within 9 cycles.
